burst_data_ram: RTL and testbench
=================================

# burst_data_ram

Parametrised, burst-capable successor to `data_ram`: the slave-side data memory behind `masterPort`, reached through the `master2slave` / `slave2master` bundles. Adds three things the single-beat RAM lacks:
- multi-beat read and write bursts
- a `waitrequest` backpressure output
- configurable depth, width and read latency

Used as the data memory of the multicycle RISC-V core and as the target for `masterPort` burst testing.

## Interface
Parameters:
- DATA_W, 32, data bus width in bits; multiple of 8.
- DEPTH_WORDS, 1024, memory depth in words; power of two.
- ADDR_W, 32, byte-address width.
- BURST_W, 4, width of `burstcount`; maximum burst length is 2^BURST_W-1.
- READ_LATENCY, 1, cycles from read-beat issue to `valid`; legal range 1..4.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- read  in  1  read command request.
- write  in  1  write beat request.
- byteena  in  DATA_W/8  byte enables for writes and read lane masking.
- burstcount  in  BURST_W  beats in the burst; sampled on the first beat only.
- addr  in  ADDR_W  byte address; sampled on the first beat only.
- wdata  in  DATA_W  write data.
- waitrequest  out  1  high means the request is not accepted this cycle.
- valid  out  1  read data beat valid.
- rdata  out  DATA_W  read data.

## Operation
- Word index is `addr[log2(DEPTH_WORDS)+log2(DATA_W/8)-1 : log2(DATA_W/8)]`.
  - Low byte-offset bits are ignored.
  - Upper bits are ignored, so addresses wrap modulo the depth.
  - Beat addresses increment by one word and also wrap modulo the depth.
- A request is accepted in any cycle where it is high and `waitrequest` is low.
- `burstcount` of 0 is treated as 1.
- FSM states are IDLE, WR_BURST, RD_BURST.
- IDLE:
  - Accepted write:
    - writes beat 0 to `mem[base]` with `byteena`.
    - latches base+1 and remaining = count-1.
    - goes to WR_BURST if remaining > 0, otherwise stays in IDLE.
  - Accepted read:
    - latches base, count and `byteena`.
    - goes to RD_BURST.
  - `read` and `write` high together: treated as a write; the read is not accepted.
- WR_BURST:
  - `waitrequest` stays low.
  - Each cycle with `write` high writes the next word and decrements remaining.
  - `write` low is a master stall: nothing is written and state is held.
  - `addr`, `burstcount` and `read` are ignored.
  - Returns to IDLE on the beat that makes remaining 0.
- RD_BURST:
  - `waitrequest` is high.
  - One memory read is issued per cycle, with no gaps, until `count` beats are issued.
  - Returned data has byte lanes with latched `byteena`=0 forced to 0.
  - No shifting or sign extension; that is done by the master.
  - Returns to IDLE after the last beat leaves the read pipeline.
- Memory contents are never cleared by reset.
- Reset mid-burst:
  - aborts the burst.
  - clears the pipeline, counters and FSM to IDLE.
  - a write beat in flight at reset assertion is not performed.

## Timing
- Reset values: `waitrequest`=1, `valid`=0, `rdata`=0, FSM=IDLE.
  - `waitrequest` falls at the first rising edge after `rst` deasserts.
- Write: a beat accepted at edge N is visible in memory to a read issued at edge N+1 or later.
- Read, command accepted at edge N:
  - beat k (k = 0..count-1) is presented with `valid`=1 in the cycle after edge N+READ_LATENCY+k.
  - `valid` is 0 between bursts and is never high for unrequested beats.
- `waitrequest` goes high in the cycle after read acceptance.
- `waitrequest` stays high through the cycle carrying the last `valid` beat.
- `waitrequest` is low in the next cycle, so the earliest back-to-back read command is one cycle after the final beat.
- `rdata` holds its last value while `valid`=0.

## Structure
- `Inc/data_type.svh` gains:
  - `ram_state_t` enum {IDLE, WR_BURST, RD_BURST}.
  - a `RAM_MAX_LATENCY`=4 constant.
- Existing `port_transmite_type` / `port_receive_type` remain the bundles connected at the testbench level.
- Sub-module `ram_read_pipe`:
  - READ_LATENCY-deep shift register of {valid, data, lane mask}.
  - Output masking is applied at its last stage.

## Test plan
- Reset: hold `rst`=0 for 3 cycles → `waitrequest`=1, `valid`=0, `rdata`=0; `waitrequest`=0 one edge after release.
- Single write then read: write 0xDEADBEEF to addr 0x10, `byteena`=0xF; then read addr 0x10, `byteena`=0x3 → one `valid` pulse, `rdata`=0x0000BEEF, at edge accept+READ_LATENCY.
- Write burst of 8 at addr 0x20, with `write` dropped for 2 cycles after beat 3 → words 8..15 hold the 8 data values in order, and the stall writes nothing.
- Read burst of 8 at 0x20 with READ_LATENCY=1 and again with READ_LATENCY=3:
  - 8 consecutive `valid` beats with the correct data.
  - `waitrequest` high throughout and low the cycle after beat 7.
- Wrap: DEPTH_WORDS=16, 4-beat write at addr 0x38 → words 14, 15, 0, 1 written; addr 0x78 aliases word 14.
- Reset asserted mid read burst after beat 2 → `valid` drops immediately and no further beats appear; a new read after release returns correct data.

Source files
------------

// File: rtl/burst_data_ram_pkg.sv
// -----------------------------------------------------------------------------
// burst_data_ram_pkg
//   Shared types and constants for the burst-capable data RAM.
//   - ram_state_t     : control FSM states
//   - RAM_MAX_LATENCY : deepest supported read pipeline (READ_LATENCY 1..4)
// -----------------------------------------------------------------------------
package burst_data_ram_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WR_BURST = 2'd1,
      RD_BURST = 2'd2
   } ram_state_t;

   localparam int RAM_MAX_LATENCY = 4;

endpackage : burst_data_ram_pkg

// File: rtl/burst_data_ram_read_pipe.sv
// -----------------------------------------------------------------------------
// ram_read_pipe
//   READ_LATENCY-deep shift register carrying {valid, data, lane mask} for each
//   issued read beat. Stage 0 captures the memory word. Byte lanes whose mask
//   bit is 0 are forced to zero at the last stage.
//   Data and mask only advance alongside a valid beat, so the output holds
//   its last value between bursts.
//
//   Ports
//     clk       in   clock, rising edge
//     rst       in   asynchronous active-low reset
//     in_valid  in   a read beat is issued this cycle
//     in_data   in   memory word addressed by the issued beat
//     in_mask   in   byte-lane mask latched with the read command
//     out_valid out  beat presented on out_data
//     out_data  out  masked read data
//     busy      out  a beat is still in flight ahead of the last stage
// -----------------------------------------------------------------------------
module ram_read_pipe
   import burst_data_ram_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic [DATA_W-1:0]   in_data,
   input  logic [DATA_W/8-1:0] in_mask,
   output logic                out_valid,
   output logic [DATA_W-1:0]   out_data,
   output logic                busy
);

   localparam int NB   = DATA_W / 8;
   localparam int LAST = READ_LATENCY - 1;

   logic              s_valid [READ_LATENCY];
   logic [DATA_W-1:0] s_data  [READ_LATENCY];
   logic [NB-1:0]     s_mask  [READ_LATENCY];

   // NOTE: sequential state uses non-blocking assignments so every stage
   // samples the value its predecessor held before this edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < READ_LATENCY; i++) begin
            s_valid[i] <= 1'b0;
            s_data[i]  <= '0;
            s_mask[i]  <= '0;
         end
      end else begin
         s_valid[0] <= in_valid;
         if (in_valid) begin
            s_data[0] <= in_data;
            s_mask[0] <= in_mask;
         end
         for (int i = 1; i < READ_LATENCY; i++) begin
            s_valid[i] <= s_valid[i-1];
            if (s_valid[i-1]) begin
               s_data[i] <= s_data[i-1];
               s_mask[i] <= s_mask[i-1];
            end
         end
      end
   end

   assign out_valid = s_valid[LAST];

   always_comb begin
      for (int b = 0; b < NB; b++) begin
         out_data[b*8 +: 8] = s_mask[LAST][b] ? s_data[LAST][b*8 +: 8] : 8'h00;
      end
   end

   // Only stages ahead of the last one count: the last stage's beat is the
   // one being presented, and the FSM may leave RD_BURST while it is shown.
   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < LAST; i++) begin
         busy = busy | s_valid[i];
      end
   end

endmodule : ram_read_pipe

// File: rtl/burst_data_ram.sv
// -----------------------------------------------------------------------------
// burst_data_ram
//   Slave-side data memory with multi-beat read/write bursts, waitrequest
//   backpressure and a configurable read latency (1..RAM_MAX_LATENCY).
//   Addresses are byte addresses; the word index wraps modulo DEPTH_WORDS,
//   both for the first beat and for every following beat.
//
//   Ports
//     clk          in   clock, rising edge
//     rst          in   asynchronous active-low reset
//     read         in   read command request
//     write        in   write beat request
//     byteena      in   write byte enables / read lane mask
//     burstcount   in   beats in burst (0 treated as 1), first beat only
//     addr         in   byte address, first beat only
//     wdata        in   write data
//     waitrequest  out  request not accepted this cycle
//     valid        out  read data beat valid
//     rdata        out  read data
// -----------------------------------------------------------------------------
module burst_data_ram
   import burst_data_ram_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int DEPTH_WORDS  = 1024,
   parameter int ADDR_W       = 32,
   parameter int BURST_W      = 4,
   parameter int READ_LATENCY = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                read,
   input  logic                write,
   input  logic [DATA_W/8-1:0] byteena,
   input  logic [BURST_W-1:0]  burstcount,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W-1:0]   wdata,
   output logic                waitrequest,
   output logic                valid,
   output logic [DATA_W-1:0]   rdata
);

   localparam int NB       = DATA_W / 8;
   localparam int BYTE_OFF = $clog2(NB);
   localparam int IDX_W    = $clog2(DEPTH_WORDS);

   ram_state_t         state, state_next;
   logic [IDX_W-1:0]   addr_idx;
   logic [IDX_W-1:0]   wr_ptr, rd_ptr, mem_waddr;
   logic [BURST_W-1:0] burst_eff, wr_left, rd_left;
   logic [NB-1:0]      rd_mask;
   logic               mem_we, cmd_wr, cmd_rd, issue, pipe_busy;
   logic [DATA_W-1:0]  mem [DEPTH_WORDS];

   // Byte-offset and upper address bits are deliberately dropped.
   logic unused_addr;
   assign unused_addr = ^addr;

   assign addr_idx  = addr[IDX_W+BYTE_OFF-1 -: IDX_W];
   assign burst_eff = (burstcount == '0) ? BURST_W'(1) : burstcount;

   // NOTE: every signal written here gets a default first, so no path
   // through the case statement can infer a latch.
   always_comb begin
      state_next = state;
      mem_we     = 1'b0;
      mem_waddr  = wr_ptr;
      cmd_wr     = 1'b0;
      cmd_rd     = 1'b0;
      issue      = 1'b0;
      case (state)
         IDLE: begin
            // waitrequest is still high for the first cycle out of reset.
            if (!waitrequest) begin
               if (write) begin
                  // A simultaneous read is dropped: write wins.
                  cmd_wr    = 1'b1;
                  mem_we    = 1'b1;
                  mem_waddr = addr_idx;
                  if (burst_eff != BURST_W'(1)) state_next = WR_BURST;
               end else if (read) begin
                  cmd_rd     = 1'b1;
                  state_next = RD_BURST;
               end
            end
         end
         WR_BURST: begin
            if (write) begin
               mem_we = 1'b1;
               if (wr_left == BURST_W'(1)) state_next = IDLE;
            end
         end
         RD_BURST: begin
            issue = (rd_left != '0);
            if (rd_left == '0 && !pipe_busy) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         waitrequest <= 1'b1;
         wr_ptr      <= '0;
         wr_left     <= '0;
         rd_ptr      <= '0;
         rd_left     <= '0;
         rd_mask     <= '0;
      end else begin
         state       <= state_next;
         waitrequest <= (state_next == RD_BURST);
         if (cmd_wr) begin
            wr_ptr  <= addr_idx + IDX_W'(1);
            wr_left <= burst_eff - BURST_W'(1);
         end else if (state == WR_BURST && write) begin
            wr_ptr  <= wr_ptr + IDX_W'(1);
            wr_left <= wr_left - BURST_W'(1);
         end
         if (cmd_rd) begin
            rd_ptr  <= addr_idx;
            rd_left <= burst_eff;
            rd_mask <= byteena;
         end else if (issue) begin
            rd_ptr  <= rd_ptr + IDX_W'(1);
            rd_left <= rd_left - BURST_W'(1);
         end
      end
   end

   // NOTE: the storage array has no reset; contents survive rst, and a
   // resettable array would not map onto RAM macros.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < NB; b++) begin
            if (byteena[b]) mem[mem_waddr][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
   end

   ram_read_pipe #(
      .DATA_W       (DATA_W),
      .READ_LATENCY (READ_LATENCY)
   ) u_read_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (issue),
      .in_data   (mem[rd_ptr]),
      .in_mask   (rd_mask),
      .out_valid (valid),
      .out_data  (rdata),
      .busy      (pipe_busy)
   );

endmodule : burst_data_ram

// File: tb/tb_burst_data_ram.sv
// -----------------------------------------------------------------------------
// tb_burst_data_ram
//   Three instances share one stimulus stream:
//     [0] depth 1024, latency 1   [1] depth 1024, latency 3
//     [2] depth 16,   latency 2   (address wrap)
//   Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_burst_data_ram;

   logic        clk = 1'b0;
   logic        rst;
   logic        read, write;
   logic [3:0]  byteena, burstcount;
   logic [31:0] addr, wdata;

   logic        wreq [3];
   logic        vld  [3];
   logic [31:0] rdt  [3];

   int          lat [3] = '{1, 3, 2};
   int          n_cmp = 0;
   int          n_mis = 0;
   logic [31:0] wr_q  [16];
   logic [31:0] exp_q [16];
   logic [31:0] bdata [8];

   always #5 clk = ~clk;

   burst_data_ram #(.DATA_W(32), .DEPTH_WORDS(1024), .ADDR_W(32), .BURST_W(4), .READ_LATENCY(1)) u_l1 (
      .clk(clk), .rst(rst), .read(read), .write(write), .byteena(byteena),
      .burstcount(burstcount), .addr(addr), .wdata(wdata),
      .waitrequest(wreq[0]), .valid(vld[0]), .rdata(rdt[0]));

   burst_data_ram #(.DATA_W(32), .DEPTH_WORDS(1024), .ADDR_W(32), .BURST_W(4), .READ_LATENCY(3)) u_l3 (
      .clk(clk), .rst(rst), .read(read), .write(write), .byteena(byteena),
      .burstcount(burstcount), .addr(addr), .wdata(wdata),
      .waitrequest(wreq[1]), .valid(vld[1]), .rdata(rdt[1]));

   burst_data_ram #(.DATA_W(32), .DEPTH_WORDS(16), .ADDR_W(32), .BURST_W(4), .READ_LATENCY(2)) u_wrap (
      .clk(clk), .rst(rst), .read(read), .write(write), .byteena(byteena),
      .burstcount(burstcount), .addr(addr), .wdata(wdata),
      .waitrequest(wreq[2]), .valid(vld[2]), .rdata(rdt[2]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] lane_mask(input logic [3:0] be);
      return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   endfunction

   task automatic wait_idle(input string tag);
      int k = 0;
      while ((wreq[0] | wreq[1] | wreq[2]) && k < 16) begin
         @(negedge clk);
         k++;
      end
      check(tag, {31'b0, wreq[0] | wreq[1] | wreq[2]}, 32'h0);
   endtask

   // Writes wr_q[0..n-1] starting at byte address a; write drops for two
   // cycles before beat stall_after. Ignored inputs are driven with junk.
   task automatic wr_burst(input logic [31:0] a, input int n, input int stall_after);
      wait_idle($sformatf("wr%0h idle", a));
      write = 1'b1; read = 1'b0; addr = a; burstcount = 4'(n);
      byteena = 4'hF; wdata = wr_q[0];
      @(negedge clk);
      for (int b = 1; b < n; b++) begin
         for (int i = 0; i < 3; i++) check($sformatf("wr%0h b%0d i%0d wait", a, b, i), {31'b0, wreq[i]}, 32'h0);
         if (b == stall_after) begin
            write = 1'b0; wdata = 32'hBAD0_BAD0;
            repeat (2) begin
               @(negedge clk);
               for (int i = 0; i < 3; i++) check($sformatf("wr%0h stall i%0d wait", a, i), {31'b0, wreq[i]}, 32'h0);
            end
         end
         write = 1'b1; read = 1'b1; addr = 32'h0000_0FF0; burstcount = 4'hF;
         wdata = wr_q[b];
         @(negedge clk);
      end
      write = 1'b0; read = 1'b0;
   endtask

   // Issues a read and checks valid/waitrequest/rdata cycle by cycle against
   // exp_q for every instance enabled in en. t counts falling edges after the
   // accepting rising edge.
   task automatic do_read(input logic [31:0] a, input logic [3:0] bc, input logic [3:0] be,
                          input int n, input logic [2:0] en);
      logic ev, ew;
      wait_idle($sformatf("rd%0h idle", a));
      read = 1'b1; write = 1'b0; addr = a; burstcount = bc; byteena = be;
      @(negedge clk);
      read = 1'b0; addr = 32'hFFFF_FFF0; byteena = 4'h0;
      for (int t = 0; t < n + 5; t++) begin
         for (int i = 0; i < 3; i++) begin
            if (en[i]) begin
               ev = (t >= lat[i]) && (t < lat[i] + n);
               ew = (t < lat[i] + n);
               check($sformatf("rd%0h i%0d t%0d valid", a, i, t), {31'b0, vld[i]}, {31'b0, ev});
               check($sformatf("rd%0h i%0d t%0d wait", a, i, t), {31'b0, wreq[i]}, {31'b0, ew});
               if (ev)
                  check($sformatf("rd%0h i%0d t%0d data", a, i, t), rdt[i], exp_q[t-lat[i]] & lane_mask(be));
               else if (t >= lat[i] + n)
                  check($sformatf("rd%0h i%0d t%0d hold", a, i, t), rdt[i], exp_q[n-1] & lane_mask(be));
            end
         end
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b0; read = 1'b0; write = 1'b0; byteena = 4'h0;
      burstcount = 4'h0; addr = 32'h0; wdata = 32'h0;
      for (int i = 0; i < 8; i++) bdata[i] = 32'hA5A5_0000 | (32'h0101 * (i + 1));

      // Reset values, and waitrequest falling one edge after release.
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("rst i%0d wait", i), {31'b0, wreq[i]}, 32'h1);
         check($sformatf("rst i%0d valid", i), {31'b0, vld[i]}, 32'h0);
         check($sformatf("rst i%0d rdata", i), rdt[i], 32'h0);
      end
      rst = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) check($sformatf("rel i%0d wait hi", i), {31'b0, wreq[i]}, 32'h1);
      @(negedge clk);
      for (int i = 0; i < 3; i++) check($sformatf("rel i%0d wait lo", i), {31'b0, wreq[i]}, 32'h0);

      // Single write then masked single read.
      wr_q[0] = 32'hDEAD_BEEF;
      wr_burst(32'h10, 1, -1);
      exp_q[0] = 32'hDEAD_BEEF;
      do_read(32'h10, 4'h1, 4'h3, 1, 3'b111);

      // burstcount 0 behaves as a single beat.
      do_read(32'h10, 4'h0, 4'hF, 1, 3'b111);

      // Sentinel just past the burst region (word 16; word 0 on the wrap part).
      wr_q[0] = 32'h5555_AAAA;
      wr_burst(32'h40, 1, -1);

      // 8-beat write burst with a two-cycle stall before beat 4.
      for (int i = 0; i < 8; i++) wr_q[i] = bdata[i];
      wr_burst(32'h20, 8, 4);
      for (int i = 0; i < 8; i++) exp_q[i] = bdata[i];
      do_read(32'h20, 4'h8, 4'hF, 8, 3'b111);
      exp_q[0] = 32'h5555_AAAA;
      do_read(32'h40, 4'h1, 4'hF, 1, 3'b111);

      // Reset asserted while latency-1 instance shows beat 2.
      wait_idle("mid idle");
      read = 1'b1; addr = 32'h20; burstcount = 4'h8; byteena = 4'hF;
      @(negedge clk);
      read = 1'b0;
      repeat (3) @(negedge clk);
      check("mid beat2 valid", {31'b0, vld[0]}, 32'h1);
      check("mid beat2 data", rdt[0], bdata[2]);
      rst = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("mid i%0d valid", i), {31'b0, vld[i]}, 32'h0);
         check($sformatf("mid i%0d wait", i), {31'b0, wreq[i]}, 32'h1);
      end
      repeat (2) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) check($sformatf("mid hold i%0d valid", i), {31'b0, vld[i]}, 32'h0);
      end
      rst = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) check($sformatf("mid rel i%0d wait", i), {31'b0, wreq[i]}, 32'h0);
      exp_q[0] = bdata[0]; exp_q[1] = bdata[1];
      do_read(32'h20, 4'h2, 4'hF, 2, 3'b111);

      // Wrap: 0x38 is word 14; on the 16-word part the burst covers 14,15,0,1.
      wr_q[0] = 32'h1111_0001; wr_q[1] = 32'h2222_0002;
      wr_q[2] = 32'h3333_0003; wr_q[3] = 32'h4444_0004;
      wr_burst(32'h38, 4, -1);
      for (int i = 0; i < 4; i++) exp_q[i] = wr_q[i];
      do_read(32'h38, 4'h4, 4'hF, 4, 3'b111);
      exp_q[0] = 32'h1111_0001;
      do_read(32'h78, 4'h1, 4'hF, 1, 3'b100);
      exp_q[0] = 32'h3333_0003;
      do_read(32'h00, 4'h1, 4'hF, 1, 3'b100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule : tb_burst_data_ram
